// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// Existing 1-bit full adder used as the serial adder's arithmetic cell.
module adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock (LSB first)
// into a single full adder and collects the sum and the rippled carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s, co;
  logic             last;
  logic             accept;

  adder u_adder (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .co (co),
    .s  (s)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Back-to-back: a start seen in DONE is accepted just like in IDLE.
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        carry <= cin_in;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= {s, s_sh[WIDTH-1:1]};
        carry <= co;
        if (last) begin
          // Counter restarts rather than wrapping so it never passes WIDTH-1.
          cnt     <= '0;
          sum_out <= {s, s_sh[WIDTH-1:1]};
          cout    <= co;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
